// File: rtl/display_capture_pkg.sv
`default_nettype none
// ============================================================================
// Module   : display_capture_pkg
// Brief    : Shared FSM encodings and idle line levels for display_capture.
// Revision : 1.0 - initial release
// ============================================================================
package display_capture_pkg;

    localparam logic [1:0] S_SHIFT   = 2'd0;
    localparam logic [1:0] S_LATCHED = 2'd1;
    localparam logic [1:0] S_ON      = 2'd2;

    localparam logic c_oclk_idle = 1'b0;
    localparam logic c_lat_idle  = 1'b1;
    localparam logic c_oe_idle   = 1'b1;

endpackage
`default_nettype wire

// File: rtl/display_capture_edge_sampler.sv
`default_nettype none
// ============================================================================
// Module   : display_capture_edge_sampler
// Brief    : Two-stage sampler with registered edge pulse for one panel control
//            line; a payload bus travels alongside so it stays aligned with the pulse.
// Revision : 1.0 - initial release
// ============================================================================
module display_capture_edge_sampler #(
    parameter logic          IDLE     = 1'b0,
    parameter bit            RISE     = 1'b1,
    parameter int            PW       = 1,
    parameter logic [PW-1:0] PAY_IDLE = '0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_line,
    input  logic [PW-1:0] i_payload,
    output logic          o_edge,
    output logic [PW-1:0] o_payload
);

    logic          r_s1;
    logic          r_s2;
    logic          r_edge;
    logic [PW-1:0] r_pay_s1;
    logic [PW-1:0] r_pay_s2;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1     <= IDLE;
            r_s2     <= IDLE;
            r_edge   <= 1'b0;
            r_pay_s1 <= PAY_IDLE;
            r_pay_s2 <= PAY_IDLE;
        end else begin
            r_s1     <= i_line;
            r_s2     <= r_s1;
            r_edge   <= RISE ? (r_s1 & ~r_s2) : (~r_s1 & r_s2);
            // payload delayed one more stage so it matches the registered edge
            r_pay_s1 <= i_payload;
            r_pay_s2 <= r_pay_s1;
        end
    end

    assign o_edge    = r_edge;
    assign o_payload = r_pay_s2;

endmodule
`default_nettype wire

// File: rtl/display_capture.sv
`default_nettype none
// ============================================================================
// Module   : display_capture
// Brief    : Panel interface receiver; rebuilds each latched line with its row
//            address and measured oe-low on-time, handed out over valid/ready.
// Revision : 1.0 - initial release
// ============================================================================
module display_capture
    import display_capture_pkg::*;
#(
    parameter int ROWS    = 8,
    parameter int COLUMNS = 32,
    parameter int LANES   = 2,
    parameter int MAX_ON  = 255,
    localparam int ROW_W  = $clog2(ROWS),
    localparam int ON_W   = $clog2(MAX_ON + 1),
    localparam int COL_W  = $clog2(COLUMNS + 1),
    localparam int CI_W   = $clog2(COLUMNS)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_oclk,
    input  logic                     in_lat,
    input  logic                     in_oe,
    input  logic [ROW_W-1:0]         in_row,
    input  logic [LANES-1:0]         in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [ROW_W-1:0]         out_row,
    output logic [LANES*COLUMNS-1:0] out_data,
    output logic [ON_W-1:0]          out_on,
    output logic                     out_len_err,
    output logic                     frame_done,
    output logic                     overflow
);

    logic             w_oclk_rise;
    logic             w_lat_fall;
    logic             w_oe_rise;
    logic [LANES-1:0] w_data;
    logic [ROW_W-1:0] w_row;
    logic             w_oe_lvl;

    display_capture_edge_sampler #(
        .IDLE(c_oclk_idle), .RISE(1'b1), .PW(LANES), .PAY_IDLE('0)
    ) u_oclk (
        .clk(clk), .rst(rst), .i_line(in_oclk), .i_payload(in_data),
        .o_edge(w_oclk_rise), .o_payload(w_data)
    );

    display_capture_edge_sampler #(
        .IDLE(c_lat_idle), .RISE(1'b0), .PW(ROW_W), .PAY_IDLE('0)
    ) u_lat (
        .clk(clk), .rst(rst), .i_line(in_lat), .i_payload(in_row),
        .o_edge(w_lat_fall), .o_payload(w_row)
    );

    display_capture_edge_sampler #(
        .IDLE(c_oe_idle), .RISE(1'b1), .PW(1), .PAY_IDLE(c_oe_idle)
    ) u_oe (
        .clk(clk), .rst(rst), .i_line(in_oe), .i_payload(in_oe),
        .o_edge(w_oe_rise), .o_payload(w_oe_lvl)
    );

    // A latch coinciding with an oclk rise closes the line first; the bit opens the next one.
    logic [COL_W-1:0]         r_col_cnt;
    logic                     r_extra;
    logic                     w_shift_en;
    logic [CI_W-1:0]          w_shift_col;
    logic [LANES*COLUMNS-1:0] w_shift;

    assign w_shift_en  = w_oclk_rise && (w_lat_fall || (r_col_cnt != COL_W'(COLUMNS)));
    assign w_shift_col = w_lat_fall ? '0 : r_col_cnt[CI_W-1:0];

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        logic [COLUMNS-1:0] r_lane;
        always_ff @(posedge clk) begin
            if (rst)
                r_lane <= '0;
            else if (w_shift_en)
                r_lane[w_shift_col] <= w_data[g];
        end
        assign w_shift[g*COLUMNS +: COLUMNS] = r_lane;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_col_cnt <= '0;
            r_extra   <= 1'b0;
        end else if (w_lat_fall) begin
            r_col_cnt <= w_oclk_rise ? COL_W'(1) : '0;
            r_extra   <= 1'b0;
        end else if (w_oclk_rise) begin
            if (r_col_cnt == COL_W'(COLUMNS))
                r_extra <= 1'b1;
            else
                r_col_cnt <= r_col_cnt + COL_W'(1);
        end
    end

    logic [1:0]               r_state;
    logic [ON_W-1:0]          r_on_cnt;
    logic [LANES*COLUMNS-1:0] r_hold_data;
    logic [ROW_W-1:0]         r_hold_row;
    logic                     r_hold_len_err;
    logic                     r_out_valid;
    logic [ROW_W-1:0]         r_out_row;
    logic [LANES*COLUMNS-1:0] r_out_data;
    logic [ON_W-1:0]          r_out_on;
    logic                     r_out_len_err;
    logic                     r_frame_done;
    logic                     r_overflow;
    logic                     w_emit;

    always_comb begin
        w_emit = 1'b0;
        if (w_lat_fall)
            w_emit = (r_state != S_SHIFT);
        else if (r_state == S_LATCHED)
            w_emit = w_oclk_rise;
        else if (r_state == S_ON)
            w_emit = w_oe_rise;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= S_SHIFT;
            r_on_cnt       <= '0;
            r_hold_data    <= '0;
            r_hold_row     <= '0;
            r_hold_len_err <= 1'b0;
            r_out_valid    <= 1'b0;
            r_out_row      <= '0;
            r_out_data     <= '0;
            r_out_on       <= '0;
            r_out_len_err  <= 1'b0;
            r_frame_done   <= 1'b0;
            r_overflow     <= 1'b0;
        end else begin
            if (w_lat_fall) begin
                r_hold_data    <= w_shift;
                r_hold_row     <= w_row;
                r_hold_len_err <= (r_col_cnt != COL_W'(COLUMNS)) || r_extra;
                r_on_cnt       <= '0;
                r_state        <= S_LATCHED;
            end else begin
                case (r_state)
                    S_LATCHED: begin
                        if (w_oclk_rise) begin
                            r_state <= S_SHIFT;
                        end else if (!w_oe_lvl) begin
                            r_on_cnt <= ON_W'(1);
                            r_state  <= S_ON;
                        end
                    end
                    S_ON: begin
                        if (w_oe_rise)
                            r_state <= S_SHIFT;
                        else if (!w_oe_lvl && (r_on_cnt != ON_W'(MAX_ON)))
                            r_on_cnt <= r_on_cnt + ON_W'(1);
                    end
                    default: r_state <= S_SHIFT;
                endcase
            end

            r_frame_done <= r_out_valid && out_ready && (r_out_row == ROW_W'(ROWS - 1));

            // A record arriving while the previous one is still refused is lost.
            if (w_emit && r_out_valid && !out_ready) begin
                r_overflow <= 1'b1;
            end else if (w_emit) begin
                r_out_valid   <= 1'b1;
                r_out_row     <= r_hold_row;
                r_out_data    <= r_hold_data;
                r_out_on      <= r_on_cnt;
                r_out_len_err <= r_hold_len_err;
            end else if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_valid   = r_out_valid;
    assign out_row     = r_out_row;
    assign out_data    = r_out_data;
    assign out_on      = r_out_on;
    assign out_len_err = r_out_len_err;
    assign frame_done  = r_frame_done;
    assign overflow    = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_display_capture.sv
`default_nettype none
// ============================================================================
// Module   : tb_display_capture
// Brief    : Self-checking bench for display_capture against a line-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_display_capture;

    localparam int ROWS    = 8;
    localparam int COLUMNS = 32;
    localparam int MAX_ON  = 255;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_oclk, in_lat, in_oe;
    logic [2:0]  in_row;
    logic [1:0]  in_data;
    logic        out_valid, out_ready;
    logic [2:0]  out_row;
    logic [63:0] out_data;
    logic [7:0]  out_on;
    logic        out_len_err, frame_done, overflow;

    display_capture dut (
        .clk(clk), .rst(rst), .in_oclk(in_oclk), .in_lat(in_lat), .in_oe(in_oe),
        .in_row(in_row), .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_row(out_row), .out_data(out_data), .out_on(out_on), .out_len_err(out_len_err),
        .frame_done(frame_done), .overflow(overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  row;
        logic [63:0] data;
        logic [7:0]  on;
        logic        len_err;
    } rec_t;

    rec_t        q_exp[$];
    logic [31:0] m_lane [2];
    int          m_col;
    bit          m_extra, m_latched;
    rec_t        m_hold;

    int n_checks = 0;
    int n_errors = 0;
    int ready_mode = 1;   // 0 refuse, 1 always accept, 2 random with bounded wait
    int fd_seen = 0;
    int fd_exp  = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Line-level reference: columns fill in order, latch snapshots the line,
    // a pending line is reported when oe ends, at the next oclk, or at the next latch.
    function automatic void m_emit(input int on);
        rec_t r;
        if (m_latched) begin
            r    = m_hold;
            r.on = 8'(on);
            q_exp.push_back(r);
            m_latched = 1'b0;
        end
    endfunction

    function automatic void m_bit(input logic b0, input logic b1);
        if (m_col < COLUMNS) begin
            m_lane[0][m_col] = b0;
            m_lane[1][m_col] = b1;
            m_col++;
        end else begin
            m_extra = 1'b1;
        end
    endfunction

    function automatic void m_latch(input int row);
        m_emit(0);
        m_hold.row     = 3'(row);
        m_hold.data    = {m_lane[1], m_lane[0]};
        m_hold.len_err = (m_col != COLUMNS) || m_extra;
        m_hold.on      = 8'd0;
        m_col     = 0;
        m_extra   = 1'b0;
        m_latched = 1'b1;
    endfunction

    task automatic send_bits(input int n, input logic [63:0] v0, input logic [63:0] v1);
        for (int i = 0; i < n; i++) begin
            m_emit(0);
            m_bit(v0[i], v1[i]);
            in_oclk = 1'b1;
            in_data = {v1[i], v0[i]};
            tick();
            in_oclk = 1'b0;
            tick();
        end
        repeat (3) tick();
    endtask

    task automatic latch(input int row, input bit with_bit, input logic b0, input logic b1);
        in_row = 3'(row);
        in_lat = 1'b0;
        m_latch(row);
        if (with_bit) begin
            in_oclk = 1'b1;
            in_data = {b1, b0};
            m_bit(b0, b1);
        end
        tick();
        in_lat  = 1'b1;
        in_oclk = 1'b0;
        repeat (4) tick();
    endtask

    task automatic oe_pulse(input int n, input bit check_lat);
        in_oe = 1'b0;
        repeat (n) tick();
        in_oe = 1'b1;
        m_emit((n > MAX_ON) ? MAX_ON : n);
        if (check_lat) begin
            tick();
            tick();
            chk("latency_pre", 64'(out_valid), 64'd0);
            tick();
            chk("latency_valid", 64'(out_valid), 64'd1);
        end
        repeat (4) tick();
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 500 && (q_exp.size() != 0 || out_valid); i++) tick();
        chk("drain_empty", 64'(q_exp.size()), 64'd0);
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        in_oclk = 1'b0;
        in_lat  = 1'b1;
        in_oe   = 1'b1;
        in_row  = '0;
        in_data = '0;
        repeat (3) tick();
        rst = 1'b0;
        m_lane[0] = '0;
        m_lane[1] = '0;
        m_col     = 0;
        m_extra   = 1'b0;
        m_latched = 1'b0;
        q_exp.delete();
        tick();
    endtask

    // Consumer: drives out_ready, scores accepted records, checks held records stay put.
    initial begin : consumer
        rec_t        e;
        logic [63:0] prev_data;
        logic [7:0]  prev_on;
        bit          prev_valid, prev_acc, r;
        int          wait_cnt;
        out_ready  = 1'b0;
        prev_valid = 1'b0;
        prev_acc   = 1'b0;
        wait_cnt   = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_valid = 1'b0;
                wait_cnt   = 0;
            end else begin
                if (frame_done) fd_seen++;
                if (prev_valid && !prev_acc) begin
                    chk("hold_valid", 64'(out_valid), 64'd1);
                    chk("hold_data", out_data, prev_data);
                    chk("hold_on", 64'(out_on), 64'(prev_on));
                end
                if (ready_mode == 0)      r = 1'b0;
                else if (ready_mode == 1) r = 1'b1;
                else                      r = ($urandom_range(0, 3) != 0) || (wait_cnt >= 2);
                out_ready = r;
                if (out_valid && r) begin
                    if (q_exp.size() == 0) begin
                        chk("unexpected_record", 64'd1, 64'd0);
                    end else begin
                        e = q_exp.pop_front();
                        chk("rec_row", 64'(out_row), 64'(e.row));
                        chk("rec_data", out_data, e.data);
                        chk("rec_on", 64'(out_on), 64'(e.on));
                        chk("rec_len_err", 64'(out_len_err), 64'(e.len_err));
                        if (e.row == 3'(ROWS - 1)) fd_exp++;
                    end
                    wait_cnt = 0;
                end else if (out_valid) begin
                    wait_cnt++;
                end
                prev_valid = out_valid;
                prev_acc   = out_valid && r;
                prev_data  = out_data;
                prev_on    = out_on;
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        logic [63:0] v0, v1;
        int          fd0, nb;
        do_reset();

        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_row", 64'(out_row), 64'd0);
        chk("rst_data", out_data, 64'd0);
        chk("rst_on", 64'(out_on), 64'd0);
        chk("rst_len_err", 64'(out_len_err), 64'd0);
        chk("rst_frame_done", 64'(frame_done), 64'd0);
        chk("rst_overflow", 64'(overflow), 64'd0);

        // Known line: lane0 only column 0 set, lane1 all ones, row 3, five on-cycles
        ready_mode = 1;
        send_bits(32, 64'h1, 64'hFFFF_FFFF_FFFF_FFFF);
        latch(3, 1'b0, 1'b0, 1'b0);
        oe_pulse(5, 1'b1);
        wait_drain();

        // Short, full and long lines
        v0 = {$urandom(), $urandom()}; v1 = {$urandom(), $urandom()};
        send_bits(31, v0, v1); latch(4, 1'b0, 1'b0, 1'b0); oe_pulse(3, 1'b0);
        v0 = {$urandom(), $urandom()}; v1 = {$urandom(), $urandom()};
        send_bits(32, v0, v1); latch(5, 1'b0, 1'b0, 1'b0); oe_pulse(2, 1'b0);
        v0 = {$urandom(), $urandom()}; v1 = {$urandom(), $urandom()};
        send_bits(34, v0, v1); latch(6, 1'b0, 1'b0, 1'b0); oe_pulse(1, 1'b0);

        // Latch together with an oclk rise, then oclk while latched
        v0 = {$urandom(), $urandom()}; v1 = {$urandom(), $urandom()};
        send_bits(32, v0, v1); latch(2, 1'b1, 1'b1, 1'b0);
        send_bits(31, v1, v0); latch(1, 1'b0, 1'b0, 1'b0); oe_pulse(4, 1'b0);
        wait_drain();

        // Saturating on-time, then a latch with no oe followed by oclk
        v0 = {$urandom(), $urandom()}; v1 = {$urandom(), $urandom()};
        send_bits(32, v0, v1); latch(2, 1'b0, 1'b0, 1'b0); oe_pulse(300, 1'b0);
        send_bits(32, v1, v0); latch(1, 1'b0, 1'b0, 1'b0);
        send_bits(32, v0, v0); latch(0, 1'b0, 1'b0, 1'b0); oe_pulse(1, 1'b0);
        wait_drain();

        // One full frame
        fd0 = fd_seen;
        for (int r = 0; r < ROWS; r++) begin
            v0 = {$urandom(), $urandom()}; v1 = {$urandom(), $urandom()};
            send_bits(32, v0, v1);
            latch(r, 1'b0, 1'b0, 1'b0);
            oe_pulse(int'($urandom_range(1, 10)), 1'b0);
        end
        wait_drain();
        repeat (3) tick();
        chk("frame_done_once", 64'(fd_seen - fd0), 64'd1);

        // Consumer stalls: first record held, second dropped
        ready_mode = 0;
        v0 = {$urandom(), $urandom()}; v1 = {$urandom(), $urandom()};
        send_bits(32, v0, v1); latch(1, 1'b0, 1'b0, 1'b0); oe_pulse(4, 1'b0);
        send_bits(32, v1, v0); latch(2, 1'b0, 1'b0, 1'b0); oe_pulse(6, 1'b0);
        repeat (5) tick();
        chk("ovf_flag", 64'(overflow), 64'd1);
        chk("ovf_valid", 64'(out_valid), 64'd1);
        chk("ovf_held_data", out_data, q_exp[0].data);
        chk("ovf_held_on", 64'(out_on), 64'(q_exp[0].on));
        q_exp.delete(1);
        ready_mode = 1;
        wait_drain();
        chk("ovf_sticky", 64'(overflow), 64'd1);

        // Reset in the middle of a line
        v0 = {$urandom(), $urandom()};
        send_bits(10, v0, v0);
        do_reset();
        repeat (10) tick();
        chk("midline_rst_valid", 64'(out_valid), 64'd0);
        chk("midline_rst_overflow", 64'(overflow), 64'd0);

        // Randomized lines with a hesitant consumer
        ready_mode = 2;
        for (int k = 0; k < 40; k++) begin
            v0 = {$urandom(), $urandom()}; v1 = {$urandom(), $urandom()};
            nb = ($urandom_range(0, 7) == 0) ? int'($urandom_range(28, 35)) : 32;
            send_bits(nb, v0, v1);
            latch(int'($urandom_range(0, ROWS - 1)), ($urandom_range(0, 9) == 0), v0[63], v1[63]);
            if ($urandom_range(0, 4) != 0) oe_pulse(int'($urandom_range(1, 20)), 1'b0);
        end
        wait_drain();
        repeat (3) tick();
        chk("rand_overflow", 64'(overflow), 64'd0);
        chk("frame_done_total", 64'(fd_seen), 64'(fd_exp));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
